// File: rtl/average_write_ctrl.sv
// Write sequencer for the 16-slot average-result bank: steps a 3-lane group select per accepted beat,
// then holds the completed vector until acknowledged. Optional idle timeout under `AVE_TIMEOUT_EN`.
module average_write_ctrl #(
  parameter int NUM_REG = 16,
  parameter int LANES   = 3,
  parameter int TIMEOUT = 1024
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_enableWrite,
  output logic [NUM_REG-1:0] o_selWrite,
  output logic [2:0]         o_group,
  output logic               o_busy,
  output logic               o_done,
  input  logic               i_ack,
  output logic               o_error
);

  localparam int NUM_GROUPS = (NUM_REG + LANES - 1) / LANES;
  localparam logic [2:0] LAST_GROUP = 3'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  state_t       state_q, state_d;
  logic [2:0]   group_q, group_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         accept;
  logic [NUM_REG-1:0] sel_write;

`ifdef AVE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic             error_q, error_d;
`endif

  always_comb begin
    state_d = state_q;
    group_d = group_q;
    accept  = (state_q == FILL) && i_valid;
`ifdef AVE_TIMEOUT_EN
    idle_cnt_d = idle_cnt_q;
    error_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = FILL;
          group_d = 3'd0;
        end
      end
      FILL: begin
        if (accept) begin
          if (group_q == LAST_GROUP) begin
            state_d = HOLD;
            group_d = 3'd0;
          end else begin
            group_d = group_q + 3'd1;
          end
        end
      end
      HOLD: begin
        // A simultaneous ack and start chains straight into the next frame.
        if (i_ack) begin
          state_d = i_start ? FILL : IDLE;
          group_d = 3'd0;
        end
      end
      default: begin
        state_d = IDLE;
        group_d = 3'd0;
      end
    endcase
`ifdef AVE_TIMEOUT_EN
    // Counter stays zero outside FILL, so every entry to FILL starts a fresh count.
    if (state_q != FILL || accept) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q == CNT_W'(TIMEOUT - 1)) begin
      idle_cnt_d = '0;
      state_d    = IDLE;
      group_d    = 3'd0;
      error_d    = 1'b1;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
`endif
    busy_d = (state_d == FILL);
    done_d = (state_d == HOLD);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      group_q <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef AVE_TIMEOUT_EN
      idle_cnt_q <= '0;
      error_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      group_q <= group_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef AVE_TIMEOUT_EN
      idle_cnt_q <= idle_cnt_d;
      error_q    <= error_d;
`endif
    end
  end

  // Group mask is combinational so the bank captures on the accepting edge.
  always_comb begin
    sel_write = '0;
    if (busy_q) begin
      for (int i = 0; i < NUM_REG; i++) begin
        if (i / LANES == int'(group_q)) sel_write[i] = 1'b1;
      end
    end
  end

  assign o_ready       = busy_q;
  assign o_enableWrite = busy_q && i_valid;
  assign o_selWrite    = sel_write;
  assign o_group       = group_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
`ifdef AVE_TIMEOUT_EN
  assign o_error       = error_q;
`else
  assign o_error       = 1'b0;
`endif

endmodule

// File: tb/tb_average_write_ctrl.sv
// Self-checking bench for average_write_ctrl: table of per-cycle vectors through a scoreboard queue,
// plus a hand-written asynchronous-reset-mid-fill sequence.
module tb_average_write_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_start = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_ack = 1'b0;
  logic        o_ready, o_enableWrite, o_busy, o_done, o_error;
  logic [15:0] o_selWrite;
  logic [2:0]  o_group;

  average_write_ctrl dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_start(i_start), .i_valid(i_valid),
    .o_ready(o_ready), .o_enableWrite(o_enableWrite), .o_selWrite(o_selWrite),
    .o_group(o_group), .o_busy(o_busy), .o_done(o_done), .i_ack(i_ack), .o_error(o_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        ready;
    logic        en;
    logic [15:0] sel;
    logic [2:0]  grp;
    logic        busy;
    logic        done;
    logic        err;
  } outs_t;

  typedef struct {
    string name;
    logic  start;
    logic  valid;
    logic  ack;
    outs_t exp;
  } vec_t;

  vec_t  vecs[$];
  outs_t sb[$];
  string sbName[$];
  int    nVec = 0;
  int    nMiss = 0;

  function automatic logic [15:0] expMask(input int g);
    case (g)
      0: return 16'h0007;
      1: return 16'h0038;
      2: return 16'h01C0;
      3: return 16'h0E00;
      4: return 16'h7000;
      5: return 16'h8000;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic outs_t idleO();
    outs_t o;
    o = '0;
    return o;
  endfunction

  function automatic outs_t fillO(input int g, input logic v);
    outs_t o;
    o = '0;
    o.ready = 1'b1;
    o.en    = v;
    o.sel   = expMask(g);
    o.grp   = 3'(g);
    o.busy  = 1'b1;
    return o;
  endfunction

  function automatic outs_t holdO();
    outs_t o;
    o = '0;
    o.done = 1'b1;
    return o;
  endfunction

  task automatic addVec(input string n, input logic s, input logic v, input logic a, input outs_t e);
    vec_t x;
    x.name = n; x.start = s; x.valid = v; x.ack = a; x.exp = e;
    vecs.push_back(x);
  endtask

  // Drive one cycle's inputs on the falling edge and queue what the DUT should show.
  task automatic applyStimulus(input vec_t v);
    @(negedge i_clk);
    i_start = v.start;
    i_valid = v.valid;
    i_ack   = v.ack;
    sb.push_back(v.exp);
    sbName.push_back(v.name);
  endtask

  task automatic checkOutput();
    outs_t exp, act;
    string n;
    #1;
    nVec++;
    if (sb.size() == 0) begin
      nMiss++;
      $display("[TB] FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    exp = sb.pop_front();
    n   = sbName.pop_front();
    act = '{o_ready, o_enableWrite, o_selWrite, o_group, o_busy, o_done, o_error};
    if (act !== exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got rdy=%b en=%b sel=%h grp=%0d busy=%b done=%b err=%b, required rdy=%b en=%b sel=%h grp=%0d busy=%b done=%b err=%b",
               n, act.ready, act.en, act.sel, act.grp, act.busy, act.done, act.err,
               exp.ready, exp.en, exp.sel, exp.grp, exp.busy, exp.done, exp.err);
    end
  endtask

  task automatic expectNow(input string n, input outs_t e);
    sb.push_back(e);
    sbName.push_back(n);
    checkOutput();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    addVec("idle_after_reset", 0, 0, 0, idleO());
    addVec("start_in_idle",    1, 0, 0, idleO());
    for (int g = 0; g < 6; g++) addVec($sformatf("full_g%0d", g), 0, 1, 0, fillO(g, 1'b1));
    for (int k = 0; k < 5; k++) addVec($sformatf("hold_start_only_%0d", k), 1, 1, 0, holdO());
    addVec("hold_ack",         0, 0, 1, holdO());
    addVec("idle_after_ack",   0, 0, 0, idleO());
    addVec("idle_ack_ignored", 0, 0, 1, idleO());
    addVec("idle_valid_nowr",  0, 1, 0, idleO());
    addVec("start_again",      1, 0, 0, idleO());
    addVec("stall_g0_beat",    0, 1, 0, fillO(0, 1'b1));
    addVec("stall_gap_a",      0, 0, 0, fillO(1, 1'b0));
    addVec("stall_gap_start",  1, 0, 0, fillO(1, 1'b0));
    addVec("stall_g1_beat",    0, 1, 0, fillO(1, 1'b1));
    addVec("stall_ack_fill",   0, 0, 1, fillO(2, 1'b0));
    addVec("stall_g2_beat",    0, 1, 0, fillO(2, 1'b1));
    addVec("stall_g3_beat",    0, 1, 0, fillO(3, 1'b1));
    addVec("stall_g4_beat",    0, 1, 0, fillO(4, 1'b1));
    addVec("stall_g5_beat",    0, 1, 0, fillO(5, 1'b1));
    addVec("stall_done",       0, 0, 0, holdO());
    addVec("b2b_ack_start",    1, 0, 1, holdO());
    addVec("b2b_g0",           0, 1, 0, fillO(0, 1'b1));
    addVec("b2b_g1",           0, 1, 0, fillO(1, 1'b1));
    addVec("b2b_g2",           0, 1, 0, fillO(2, 1'b1));

    // Reset asserted with start/valid high: everything must read zero.
    @(negedge i_clk);
    i_start = 1'b1;
    i_valid = 1'b1;
    expectNow("in_reset", idleO());
    @(negedge i_clk);
    i_start = 1'b0;
    i_valid = 1'b0;
    i_reset = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput();
    end

    // Three beats accepted; asynchronous reset mid-fill must clear outputs without a clock edge.
    @(negedge i_clk);
    i_start = 1'b0;
    i_ack   = 1'b0;
    i_valid = 1'b1;
    expectNow("pre_reset_g3", fillO(3, 1'b1));
    #2 i_reset = 1'b0;
    expectNow("async_reset_now", idleO());
    @(posedge i_clk);
    expectNow("reset_held_edge", idleO());
    @(negedge i_clk);
    i_reset = 1'b1;
    i_valid = 1'b0;
    expectNow("after_release", idleO());
    @(negedge i_clk);
    i_start = 1'b1;
    expectNow("restart_idle", idleO());
    @(negedge i_clk);
    i_start = 1'b0;
    i_valid = 1'b1;
    expectNow("restart_g0", fillO(0, 1'b1));
    @(negedge i_clk);
    expectNow("restart_g1", fillO(1, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
